// File: rtl/sp24_a_encoder.sv
// sp24_a_encoder: prunes dense 4-lane A groups to 2:4 structured sparsity and feeds a PE row.
// Datapath: accept (p0) -> magnitude stage (p1) -> prune stage (p2) -> output FIFO -> output register.
module sp24_a_encoder #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  k_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*DW-1:0]   in_data,
    input  logic              out_stall,
    output logic              out_en,
    output logic [3:0]        out_mask,
    output logic [4*DW-1:0]   out_a,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       prune_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 1 + 4 + 4*DW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // |x| widened by one bit so the most negative lane value stays exact
    function automatic logic [DW:0] abs_mag(input logic signed [DW-1:0] x);
        logic signed [DW:0] xe;
        xe = {x[DW-1], x};
        return x[DW-1] ? $unsigned(-xe) : $unsigned(xe);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        k_len_r, acc_cnt;

    logic                    accept_p0;
    logic signed [DW-1:0]    lane_p0 [4];

    logic                    vld_p1;
    logic [4*DW-1:0]         data_p1;
    logic [3:0]              nz_p1;
    logic [DW:0]             mag_p1 [4];
    logic                    last_p1;
    logic [2:0]              nzc_p1;
    logic [2:0]              beat;
    logic [3:0]              keep_p1, mask_nx_p1;
    logic [4*DW-1:0]         a_nx_p1;
    logic                    prune_p1;

    logic                    vld_p2;
    logic [3:0]              mask_p2;
    logic [4*DW-1:0]         a_p2;
    logic                    last_p2;

    logic [EW-1:0]           fifo_mem [DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           fifo_cnt, inflight;
    logic                    pop;
    logic [EW-1:0]           fifo_rd;

    // Credit-based intake: groups in the pipe and FIFO never exceed DEPTH, so the FIFO cannot overflow
    always_comb begin
        inflight  = fifo_cnt + CW'(vld_p1) + CW'(vld_p2);
        in_ready  = (state == S_RUN) && (acc_cnt < k_len_r) && (inflight < CW'(DEPTH));
        accept_p0 = in_valid && in_ready;
        pop       = (fifo_cnt != '0) && !out_stall;
        fifo_rd   = fifo_mem[rd_ptr];
        busy      = (state != S_IDLE);
        for (int i = 0; i < 4; i++) lane_p0[i] = $signed(in_data[DW*i +: DW]);
    end

    // Next-state logic; DRAIN ends on the edge that pops the tile's last word
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (k_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (acc_cnt == k_len_r) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && fifo_rd[EW-1]) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and done pulse (done lands the cycle after the last word is presented)
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == S_DONE);
        end
    end

    // Tile length latch and accepted-group counter
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            k_len_r <= '0;
            acc_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            k_len_r <= k_len;
            acc_cnt <= '0;
        end else if (accept_p0) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    // Stage p1 valid
    always_ff @(posedge clock) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= accept_p0;
    end

    // Stage p1 data: nonzero flags and magnitudes per lane; last flag rides with the group
    always_ff @(posedge clock) begin
        if (accept_p0) begin
            data_p1 <= in_data;
            last_p1 <= ((acc_cnt + CNT_W'(1)) == k_len_r);
            for (int i = 0; i < 4; i++) begin
                nz_p1[i]  <= (lane_p0[i] != '0);
                mag_p1[i] <= abs_mag(lane_p0[i]);
            end
        end
    end

    // Prune selection: a lane is kept if fewer than two lanes beat it (larger, or equal at lower index)
    always_comb begin
        nzc_p1   = popcnt4(nz_p1);
        prune_p1 = (nzc_p1 >= 3'd3);
        beat     = '0;
        keep_p1  = '0;
        a_nx_p1  = '0;
        for (int i = 0; i < 4; i++) begin
            beat = '0;
            for (int j = 0; j < 4; j++) begin
                if (j != i && ((mag_p1[j] > mag_p1[i]) || (mag_p1[j] == mag_p1[i] && j < i)))
                    beat = beat + 3'd1;
            end
            keep_p1[i] = (beat < 3'd2);
        end
        mask_nx_p1 = prune_p1 ? keep_p1 : nz_p1;
        for (int i = 0; i < 4; i++)
            a_nx_p1[DW*i +: DW] = mask_nx_p1[i] ? data_p1[DW*i +: DW] : '0;
    end

    // Stage p2 valid
    always_ff @(posedge clock) begin
        if (!rst_n) vld_p2 <= 1'b0;
        else        vld_p2 <= vld_p1;
    end

    // Stage p2 data: pruned group ready for the FIFO
    always_ff @(posedge clock) begin
        if (vld_p1) begin
            mask_p2 <= mask_nx_p1;
            a_p2    <= a_nx_p1;
            last_p2 <= last_p1;
        end
    end

    // Saturating count of groups that lost lanes in the current tile
    always_ff @(posedge clock) begin
        if (!rst_n)                        prune_cnt <= '0;
        else if (state == S_IDLE && start) prune_cnt <= '0;
        else if (vld_p1 && prune_p1)       prune_cnt <= sat_inc(prune_cnt);
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (vld_p2) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            case ({vld_p2, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (vld_p2) fifo_mem[wr_ptr] <= {last_p2, mask_p2, a_p2};
    end

    // Output register: idle cycles present an all-zero word, matching PE zeroing when en is low
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            out_en   <= 1'b0;
            out_last <= 1'b0;
            out_mask <= '0;
            out_a    <= '0;
        end else begin
            out_en                       <= pop;
            {out_last, out_mask, out_a}  <= pop ? fifo_rd : '0;
        end
    end
endmodule

// File: tb/tb_sp24_a_encoder.sv
// Bench for sp24_a_encoder: directed tiles, expected words queued at drive time, checked at the output.
module tb_sp24_a_encoder;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic              clock = 1'b0;
    logic              rst_n, start, in_valid, in_ready, out_stall;
    logic [CNT_W-1:0]  k_len;
    logic [4*DW-1:0]   in_data, out_a;
    logic              out_en, out_last, busy, done;
    logic [3:0]        out_mask;
    logic [15:0]       prune_cnt;

    sp24_a_encoder #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_stall(out_stall), .out_en(out_en), .out_mask(out_mask), .out_a(out_a),
        .out_last(out_last), .busy(busy), .done(done), .prune_cnt(prune_cnt)
    );

    always #5 clock = ~clock;

    typedef struct { logic [3:0] mask; logic [63:0] a; logic last; } exp_t;
    exp_t sb[$];

    int   n_cmp = 0, n_bad = 0, cyc = 0, n_out = 0;
    int   done_cnt = 0, done_cyc = -1, last_cyc = -1, exp_prunes = 0;
    logic stall_rand = 1'b0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference pruning: pick the largest magnitude twice, strict compare so the lower lane wins ties
    function automatic exp_t model(input logic [63:0] g, input logic last, output logic pruned);
        int mag [4];
        int cnt, b1, b2;
        logic signed [15:0] s;
        exp_t e;
        cnt = 0; b1 = -1; b2 = -1;
        for (int i = 0; i < 4; i++) begin
            s = g[16*i +: 16];
            mag[i] = (s < 0) ? -int'(s) : int'(s);
            if (s != 0) cnt++;
        end
        e.last = last;
        e.mask = 4'b0;
        if (cnt <= 2) begin
            e.a = g;
            for (int i = 0; i < 4; i++) if (mag[i] != 0) e.mask[i] = 1'b1;
            pruned = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) if (b1 < 0 || mag[i] > mag[b1]) b1 = i;
            for (int i = 0; i < 4; i++) if (i != b1 && (b2 < 0 || mag[i] > mag[b2])) b2 = i;
            e.mask[b1] = 1'b1;
            e.mask[b2] = 1'b1;
            e.a = 64'h0;
            e.a[16*b1 +: 16] = g[16*b1 +: 16];
            e.a[16*b2 +: 16] = g[16*b2 +: 16];
            pruned = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [15:0] pick_lane(input int k);
        case (k)
            0: return 16'h0000;  1: return 16'h0000;
            2: return 16'h0005;  3: return 16'hFFFB;
            4: return 16'h8000;  5: return 16'h7FFF;
            6: return 16'h0001;  default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [63:0] rand_group();
        logic [63:0] g;
        for (int i = 0; i < 4; i++) g[16*i +: 16] = pick_lane(int'($urandom_range(0, 7)));
        return g;
    endfunction

    // One clock: sample just after the edge, check any emitted word against the queue
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_en === 1'b1) begin
            chk("word expected at out_en", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_mask", out_mask, e.mask);
                chk("out_a", out_a, e.a);
                chk("out_last", out_last, e.last);
            end
            if (out_last === 1'b1) last_cyc = cyc;
            n_out++;
        end else begin
            chk("idle outputs zero", {out_last, out_mask, out_a}, 80'd0);
        end
        if (stall_rand) out_stall = ($urandom_range(0, 2) == 0);
    endtask

    task automatic drive_accept(input logic [63:0] g);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = g;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("in_ready within bound", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic push_m(input logic [63:0] g, input logic last);
        exp_t e;
        logic pr;
        e = model(g, last, pr);
        if (pr) exp_prunes++;
        sb.push_back(e);
    endtask

    task automatic send_m(input logic [63:0] g, input logic last);
        push_m(g, last);
        drive_accept(g);
    endtask

    task automatic send_exp(input logic [63:0] g, input logic [3:0] m, input logic [63:0] a, input logic last);
        exp_t e;
        e.mask = m;
        e.a    = a;
        e.last = last;
        sb.push_back(e);
        drive_accept(g);
    endtask

    task automatic start_tile(input int k);
        start = 1'b1;
        k_len = CNT_W'(k);
        tick();
        start = 1'b0;
        exp_prunes = 0;
        if (k > 0) chk("busy after start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int n, d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk("done pulse seen", done_cnt - d0, 1);
        tick();
        chk("done is one cycle", done, 0);
        chk("idle after done", busy, 0);
    endtask

    initial begin
        int d0, c0, n0, idx;
        logic [63:0] grp [8];

        rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; in_data = '0; out_stall = 1'b0;
        tick(); tick();
        chk("reset out word", {out_en, out_last, out_mask, out_a}, 80'd0);
        chk("reset ctrl", {busy, done, in_ready, prune_cnt}, 80'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a tile discards everything
        start_tile(4);
        send_m(64'h0001_0002_0003_0004, 1'b0);
        send_m(64'h0000_0000_0007_0000, 1'b0);
        sb.delete();
        d0 = done_cnt;
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 64'h0009_0009_0009_0009;
        tick(); tick();
        chk("mid-tile reset out word", {out_en, out_last, out_mask, out_a}, 80'd0);
        chk("mid-tile reset ctrl", {busy, in_ready, prune_cnt}, 80'd0);
        rst_n = 1'b1;
        tick();
        chk("in_ready low after reset", in_ready, 0);
        in_valid = 1'b0;
        in_data = '0;
        repeat (5) tick();
        chk("no done after reset", done_cnt - d0, 0);

        // Dense pass-through, minimum latency, done after the last word
        start_tile(1);
        send_exp(64'h0000_0005_0000_FFFD, 4'b0101, 64'h0000_0005_0000_FFFD, 1'b1);
        tick(); tick();
        chk("no word at accept+2", out_en, 0);
        tick();
        chk("word at accept+3", out_en, 1);
        wait_done(10);
        chk("done follows last word", done_cyc - last_cyc, 1);
        chk("dense prune_cnt", prune_cnt, 0);

        // Prune with tied magnitudes
        start_tile(1);
        send_exp(64'h0007_FFF7_0002_FFF7, 4'b0101, 64'h0000_FFF7_0000_FFF7, 1'b1);
        wait_done(10);
        chk("prune_cnt after prune", prune_cnt, 1);

        // Extremes: all most-negative lanes, then all zero lanes
        start_tile(2);
        send_exp(64'h8000_8000_8000_8000, 4'b0011, 64'h0000_0000_8000_8000, 1'b0);
        send_exp(64'h0000_0000_0000_0000, 4'b0000, 64'h0000_0000_0000_0000, 1'b1);
        wait_done(10);
        chk("extremes prune_cnt", prune_cnt, 1);

        // Start while busy must not restart the tile
        start_tile(3);
        send_m(64'h0001_0002_0003_0004, 1'b0);
        start = 1'b1;
        k_len = 8'd1;
        send_m(64'h0000_0000_0003_0000, 1'b0);
        start = 1'b0;
        send_m(64'hFFFF_0002_FFFD_0004, 1'b1);
        wait_done(20);
        chk("ignored start prune_cnt", prune_cnt, exp_prunes);

        // Backpressure: hold the PE array for 10 cycles
        for (int i = 0; i < 8; i++) grp[i] = rand_group();
        start_tile(8);
        out_stall = 1'b1;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = grp[idx];
            if (in_ready === 1'b1) begin
                push_m(grp[idx], (idx == 7));
                idx++;
            end
            tick();
            chk("no word under stall", out_en, 0);
        end
        chk("groups accepted under stall", idx, 4);
        chk("in_ready low when full", in_ready, 0);
        in_valid  = 1'b0;
        out_stall = 1'b0;
        for (int i = 4; i < 8; i++) send_m(grp[i], (i == 7));
        wait_done(50);
        chk("backpressure done timing", done_cyc - last_cyc, 1);
        chk("backpressure prune_cnt", prune_cnt, exp_prunes);

        // Random groups with random stalls
        start_tile(12);
        stall_rand = 1'b1;
        for (int i = 0; i < 12; i++) send_m(rand_group(), (i == 11));
        wait_done(300);
        stall_rand = 1'b0;
        out_stall = 1'b0;
        chk("random prune_cnt", prune_cnt, exp_prunes);

        // Empty tile
        n0 = n_out;
        start_tile(0);
        c0 = cyc;
        wait_done(6);
        chk("empty tile done timing", done_cyc - c0, 1);
        chk("empty tile emits nothing", n_out - n0, 0);

        chk("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
